// File: rtl/csr_access_unit_pkg.sv
// Shared definitions for the CSR access unit: FSM states, Zicsr funct3 codes,
// privilege codes and exception IDs.
package csr_access_unit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WRITE = 3'd2,
        ST_RESP  = 3'd3,
        ST_TRAP  = 3'd4
    } state_t;

    // Full funct3 encodings of the Zicsr instructions
    localparam logic [2:0] CSR_FUNCT3_RW  = 3'b001;
    localparam logic [2:0] CSR_FUNCT3_RS  = 3'b010;
    localparam logic [2:0] CSR_FUNCT3_RC  = 3'b011;
    localparam logic [2:0] CSR_FUNCT3_RWI = 3'b101;
    localparam logic [2:0] CSR_FUNCT3_RSI = 3'b110;
    localparam logic [2:0] CSR_FUNCT3_RCI = 3'b111;

    // funct3[1:0] selects the merge operation; funct3[2] only selects the operand source
    localparam logic [1:0] CSR_OP_RW = 2'b01;
    localparam logic [1:0] CSR_OP_RS = 2'b10;
    localparam logic [1:0] CSR_OP_RC = 2'b11;

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_S = 2'b01;
    localparam logic [1:0] PRIV_M = 2'b11;

    localparam logic [5:0] EXCEPT_ILLEGAL_INSTR = 6'd2;

    // CSR addresses with bits [11:10] == 2'b11 are read-only
    function automatic logic csr_is_ro(input logic [11:0] addr);
        return addr[11:10] == 2'b11;
    endfunction

endpackage

// File: rtl/csr_access_unit_if.sv
// Read/write port between the CSR access unit (master) and the CSR file (slave).
// Read data is combinational from the CSR file for the presented read address.
interface csr_access_unit_if;
    logic        csr_ren;
    logic [11:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic        csr_wen;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;

    modport master (
        output csr_ren, csr_raddr, csr_wen, csr_waddr, csr_wdata,
        input  csr_rdata
    );

    modport slave (
        input  csr_ren, csr_raddr, csr_wen, csr_waddr, csr_wdata,
        output csr_rdata
    );
endinterface

// File: rtl/csr_access_unit_alu.sv
// CSR ALU: merges the old CSR value with the instruction operand to form the
// full new value written back (RW replace, RS set bits, RC clear bits).
module csr_access_unit_alu
    import csr_access_unit_pkg::*;
(
    input  logic [1:0]  op_sel,
    input  logic [31:0] old_val,
    input  logic [31:0] operand,
    output logic [31:0] new_val
);

    // Read-modify-write merge; unknown selects leave the value unchanged
    always_comb begin
        new_val = old_val;
        case (op_sel)
            CSR_OP_RW: new_val = operand;
            CSR_OP_RS: new_val = old_val | operand;
            CSR_OP_RC: new_val = old_val & ~operand;
            default:   new_val = old_val;
        endcase
    end

endmodule

// File: rtl/csr_access_unit.sv
// CSR access unit: initiator side of the CSR read/write port. Accepts one Zicsr
// instruction, reads the old value, writes the merged value and returns the old
// value for rd. Illegal accesses raise a one-cycle trap ID instead.
// Build option: define CSR_PRIV_CHECK_EN to enable the privilege and read-only
// checks; without it every access proceeds and trap_id stays 0.
module csr_access_unit
    import csr_access_unit_pkg::*;
#(
    parameter logic [5:0] ILLEGAL_ID = EXCEPT_ILLEGAL_INSTR
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [2:0]          req_funct3,
    input  logic [11:0]         req_addr,
    input  logic [31:0]         req_rs1_data,
    input  logic [4:0]          req_zimm,
    input  logic [4:0]          req_rs1_idx,
    input  logic [4:0]          req_rd_idx,
    input  logic [1:0]          priv,
    input  logic                flush,
    csr_access_unit_if.master   csr,
    output logic                rsp_valid,
    output logic [31:0]         rsp_rd_data,
    output logic [5:0]          trap_id
);

`ifdef CSR_PRIV_CHECK_EN
    localparam bit PRIV_CHECK = 1'b1;
`else
    localparam bit PRIV_CHECK = 1'b0;
`endif

    state_t      state_q, state_d;
    logic [1:0]  op_sel_q, op_sel_d;
    logic [11:0] addr_q, addr_d;
    logic [31:0] operand_q, operand_d;
    logic        do_read_q, do_read_d;
    logic        do_write_q, do_write_d;
    logic [31:0] old_q, old_d;
    // Output strobes decoded from the next state so they leave a flop
    logic        ready_q, ready_d;
    logic        ren_q, ren_d;
    logic        wen_q, wen_d;
    logic        rsp_q, rsp_d;
    logic        trap_q, trap_d;

    logic        req_is_rw;
    logic        req_do_read;
    logic        req_do_write;
    logic        req_illegal;
    logic        accept;
    logic [31:0] new_val;

    // Request decode: read/write suppression and legality of the incoming access
    always_comb begin
        req_is_rw    = (req_funct3[1:0] == CSR_OP_RW);
        req_do_read  = !(req_is_rw && (req_rd_idx == 5'd0));
        req_do_write = req_is_rw || (req_rs1_idx != 5'd0);
        req_illegal  = PRIV_CHECK &&
                       ((req_addr[9:8] > priv) || (req_do_write && csr_is_ro(req_addr)));
        accept       = req_valid && ready_q && !flush;
    end

    // Next-state and datapath capture for the IDLE->READ->WRITE->RESP sequence
    always_comb begin
        state_d    = state_q;
        op_sel_d   = op_sel_q;
        addr_d     = addr_q;
        operand_d  = operand_q;
        do_read_d  = do_read_q;
        do_write_d = do_write_q;
        old_d      = old_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_sel_d   = req_funct3[1:0];
                    addr_d     = req_addr;
                    operand_d  = req_funct3[2] ? {27'd0, req_zimm} : req_rs1_data;
                    do_read_d  = req_do_read;
                    do_write_d = req_do_write;
                    old_d      = '0;
                    state_d    = req_illegal ? ST_TRAP : ST_READ;
                end
            end
            // RS/RC always read, so old holds the true value for the merge
            ST_READ: begin
                old_d   = do_read_q ? csr.csr_rdata : '0;
                state_d = ST_WRITE;
            end
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            ST_TRAP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (flush && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end
        ready_d = (state_d == ST_IDLE);
        ren_d   = (state_d == ST_READ) && do_read_d;
        wen_d   = (state_d == ST_WRITE) && do_write_d;
        rsp_d   = (state_d == ST_RESP);
        trap_d  = (state_d == ST_TRAP);
    end

    // State and capture registers; reset drops any in-flight access without writing
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_sel_q   <= '0;
            addr_q     <= '0;
            operand_q  <= '0;
            do_read_q  <= 1'b0;
            do_write_q <= 1'b0;
            old_q      <= '0;
            ready_q    <= 1'b1;
            ren_q      <= 1'b0;
            wen_q      <= 1'b0;
            rsp_q      <= 1'b0;
            trap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_sel_q   <= op_sel_d;
            addr_q     <= addr_d;
            operand_q  <= operand_d;
            do_read_q  <= do_read_d;
            do_write_q <= do_write_d;
            old_q      <= old_d;
            ready_q    <= ready_d;
            ren_q      <= ren_d;
            wen_q      <= wen_d;
            rsp_q      <= rsp_d;
            trap_q     <= trap_d;
        end
    end

    csr_access_unit_alu u_alu (
        .op_sel  (op_sel_q),
        .old_val (old_q),
        .operand (operand_q),
        .new_val (new_val)
    );

    // Flush kills the write, response and trap in the very cycle it arrives
    assign req_ready     = ready_q && !flush;
    assign csr.csr_ren   = ren_q;
    assign csr.csr_raddr = addr_q;
    assign csr.csr_wen   = wen_q && !flush;
    assign csr.csr_waddr = addr_q;
    assign csr.csr_wdata = new_val;
    assign rsp_valid     = rsp_q && !flush;
    assign rsp_rd_data   = old_q;
    assign trap_id       = (PRIV_CHECK && trap_q && !flush) ? ILLEGAL_ID : 6'd0;

endmodule

// File: tb/tb_csr_access_unit.sv
// Testbench for csr_access_unit: directed vector table, hand sequences for
// reset/flush corners, and randomized operations against a reference model.
module tb_csr_access_unit;
    import csr_access_unit_pkg::*;

`ifdef CSR_PRIV_CHECK_EN
    localparam bit PRIV_EN = 1'b1;
`else
    localparam bit PRIV_EN = 1'b0;
`endif

    typedef struct {
        logic [2:0]  f3;
        logic [11:0] addr;
        logic [31:0] rs1;
        logic [4:0]  idx;
        logic [4:0]  rd;
        logic [1:0]  priv;
        int          flush_cyc;
    } op_t;

    // Strobe masks: bit0 = cycle 1 after accept, bit2 = cycle 3
    typedef struct {
        logic [2:0]  ren;
        logic [2:0]  wen;
        logic [2:0]  rsp;
        logic [2:0]  trap;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } res_t;

    typedef struct {
        op_t         op;
        logic [31:0] init;
        res_t        want;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [11:0] req_addr;
    logic [31:0] req_rs1_data;
    logic [4:0]  req_zimm;
    logic [4:0]  req_rs1_idx;
    logic [4:0]  req_rd_idx;
    logic [1:0]  priv;
    logic        flush;
    logic        rsp_valid;
    logic [31:0] rsp_rd_data;
    logic [5:0]  trap_id;

    csr_access_unit_if bus ();

    csr_access_unit dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_rs1_data (req_rs1_data),
        .req_zimm     (req_zimm),
        .req_rs1_idx  (req_rs1_idx),
        .req_rd_idx   (req_rd_idx),
        .priv         (priv),
        .flush        (flush),
        .csr          (bus),
        .rsp_valid    (rsp_valid),
        .rsp_rd_data  (rsp_rd_data),
        .trap_id      (trap_id)
    );

    always #5 clk = ~clk;

    // Simple CSR file: combinational read, write on strobe, plus a bench preload port
    logic [31:0] mem [0:4095];
    logic [31:0] model_mem [0:4095];
    logic        pre_en;
    logic [11:0] pre_addr;
    logic [31:0] pre_val;

    assign bus.csr_rdata = mem[bus.csr_raddr];

    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_val;
        else if (bus.csr_wen) mem[bus.csr_waddr] <= bus.csr_wdata;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, want);
        end
    endtask

    // Reference model: what the port should show for one instruction given the current CSR value
    function automatic res_t model(input op_t o, input logic [31:0] cur);
        res_t        r;
        logic        is_rw;
        logic [31:0] opnd;
        logic        rd_en, wr_en, bad;
        int          alive;
        r = '{default: '0};
        is_rw = (o.f3[1:0] == 2'b01);
        opnd  = o.f3[2] ? {27'd0, o.idx} : o.rs1;
        rd_en = !(is_rw && o.rd == 5'd0);
        wr_en = is_rw || (o.idx != 5'd0);
        bad   = PRIV_EN && ((o.addr[9:8] > o.priv) || (wr_en && o.addr[11:10] == 2'b11));
        alive = (o.flush_cyc == 0) ? 4 : o.flush_cyc;
        if (bad) begin
            if (alive > 1) r.trap = 3'b001;
        end else begin
            if (rd_en) r.ren = 3'b001;
            if (wr_en && alive > 2) r.wen = 3'b010;
            if (alive > 3) r.rsp = 3'b100;
            if (is_rw) r.wdata = opnd;
            else if (o.f3[1:0] == 2'b10) r.wdata = cur | opnd;
            else r.wdata = cur & ~opnd;
            r.rdata = rd_en ? cur : 32'd0;
        end
        return r;
    endfunction

    function automatic vec_t mk(input logic [2:0] f3, input logic [11:0] addr, input logic [31:0] rs1,
                                input logic [4:0] idx, input logic [4:0] rd, input logic [1:0] pv,
                                input int fc, input logic [31:0] init,
                                input logic [2:0] ren, input logic [2:0] wen, input logic [31:0] wdata,
                                input logic [2:0] rsp, input logic [31:0] rdata, input logic [2:0] trap);
        vec_t v;
        v.op   = '{f3: f3, addr: addr, rs1: rs1, idx: idx, rd: rd, priv: pv, flush_cyc: fc};
        v.init = init;
        v.want = '{ren: ren, wen: wen, rsp: rsp, trap: trap, wdata: wdata, rdata: rdata};
        return v;
    endfunction

    task automatic preload(input logic [11:0] a, input logic [31:0] v);
        @(negedge clk);
        req_valid = 1'b0;
        flush     = 1'b0;
        pre_en    = 1'b1;
        pre_addr  = a;
        pre_val   = v;
        model_mem[a] = v;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    // Issue one instruction and record the port activity over the following three cycles
    task automatic run_op(input op_t o, output res_t ob);
        ob = '{default: '0};
        @(negedge clk);
        req_valid    = 1'b1;
        req_funct3   = o.f3;
        req_addr     = o.addr;
        req_rs1_data = o.rs1;
        req_zimm     = o.idx;
        req_rs1_idx  = o.idx;
        req_rd_idx   = o.rd;
        priv         = o.priv;
        flush        = 1'b0;
        #1 chk("req_ready_at_accept", 32'(req_ready), 32'd1);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            flush     = (o.flush_cyc == c);
            #1;
            ob.ren  = {bus.csr_ren, ob.ren[2:1]};
            ob.wen  = {bus.csr_wen, ob.wen[2:1]};
            ob.rsp  = {rsp_valid, ob.rsp[2:1]};
            ob.trap = {(trap_id != 6'd0), ob.trap[2:1]};
            if (bus.csr_ren) chk("csr_raddr", 32'(bus.csr_raddr), 32'(o.addr));
            if (bus.csr_wen) begin
                ob.wdata = bus.csr_wdata;
                chk("csr_waddr", 32'(bus.csr_waddr), 32'(o.addr));
            end
            if (rsp_valid) ob.rdata = rsp_rd_data;
            if (trap_id != 6'd0) chk("trap_id_value", 32'(trap_id), 32'd2);
        end
    endtask

    task automatic compare(input string tag, input res_t ob, input res_t want);
        chk({tag, "_ren_mask"},  32'(ob.ren),  32'(want.ren));
        chk({tag, "_wen_mask"},  32'(ob.wen),  32'(want.wen));
        chk({tag, "_rsp_mask"},  32'(ob.rsp),  32'(want.rsp));
        chk({tag, "_trap_mask"}, 32'(ob.trap), 32'(want.trap));
        if (want.wen != 3'b000 && ob.wen != 3'b000) chk({tag, "_wdata"}, ob.wdata, want.wdata);
        if (want.rsp != 3'b000 && ob.rsp != 3'b000) chk({tag, "_rd_data"}, ob.rdata, want.rdata);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_csr_ren"},   32'(bus.csr_ren), 32'd0);
        chk({tag, "_csr_wen"},   32'(bus.csr_wen), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_trap_id"},   32'(trap_id), 32'd0);
        chk({tag, "_csr_raddr"}, 32'(bus.csr_raddr), 32'd0);
        chk({tag, "_csr_waddr"}, 32'(bus.csr_waddr), 32'd0);
        chk({tag, "_csr_wdata"}, bus.csr_wdata, 32'd0);
        chk({tag, "_rsp_rd_data"}, rsp_rd_data, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vt [$];
        res_t        ob, want;
        op_t         o;
        logic [11:0] pool [0:9];
        logic [2:0]  f3s  [0:5];
        logic [1:0]  privs [0:2];

        rst = 1'b1; req_valid = 1'b0; req_funct3 = '0; req_addr = '0; req_rs1_data = '0;
        req_zimm = '0; req_rs1_idx = '0; req_rd_idx = '0; priv = PRIV_M; flush = 1'b0;
        pre_en = 1'b0; pre_addr = '0; pre_val = '0;
        repeat (3) @(negedge clk);
        #1 check_idle_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Directed table: {f3, addr, rs1, idx, rd, priv, flush_cyc, init, ren, wen, wdata, rsp, rdata, trap}
        vt.push_back(mk(CSR_FUNCT3_RW,  12'h340, 32'hDEADBEEF, 5'd7,  5'd5, PRIV_M, 0, 32'h11,
                        3'b001, 3'b010, 32'hDEADBEEF, 3'b100, 32'h11, 3'b000));
        vt.push_back(mk(CSR_FUNCT3_RS,  12'h300, 32'h0000FFFF, 5'd0,  5'd3, PRIV_M, 0, 32'h88,
                        3'b001, 3'b000, 32'h0, 3'b100, 32'h88, 3'b000));
        vt.push_back(mk(CSR_FUNCT3_RCI, 12'h304, 32'h0, 5'd8, 5'd1, PRIV_M, 0, 32'hFF,
                        3'b001, 3'b010, 32'hF7, 3'b100, 32'hFF, 3'b000));
        vt.push_back(mk(CSR_FUNCT3_RW,  12'h340, 32'h1234, 5'd2, 5'd0, PRIV_M, 0, 32'h55,
                        3'b000, 3'b010, 32'h1234, 3'b100, 32'h0, 3'b000));
        vt.push_back(mk(CSR_FUNCT3_RSI, 12'h341, 32'h0, 5'h1F, 5'd6, PRIV_M, 0, 32'h100,
                        3'b001, 3'b010, 32'h11F, 3'b100, 32'h100, 3'b000));
        vt.push_back(mk(CSR_FUNCT3_RC,  12'h342, 32'hF0F0F0F0, 5'd9, 5'd4, PRIV_M, 0, 32'hFFFFFFFF,
                        3'b001, 3'b010, 32'h0F0F0F0F, 3'b100, 32'hFFFFFFFF, 3'b000));
        vt.push_back(mk(CSR_FUNCT3_RWI, 12'h343, 32'h0, 5'h15, 5'd0, PRIV_M, 0, 32'h7,
                        3'b000, 3'b010, 32'h15, 3'b100, 32'h0, 3'b000));
        vt.push_back(mk(CSR_FUNCT3_RS,  12'h344, 32'h2, 5'd3, 5'd0, PRIV_M, 0, 32'h1,
                        3'b001, 3'b010, 32'h3, 3'b100, 32'h1, 3'b000));
        vt.push_back(mk(CSR_FUNCT3_RW,  12'h345, 32'hAA, 5'd1, 5'd2, PRIV_M, 2, 32'h77,
                        3'b001, 3'b000, 32'h0, 3'b000, 32'h0, 3'b000));
        vt.push_back(mk(CSR_FUNCT3_RS,  12'h346, 32'hF00, 5'd1, 5'd2, PRIV_M, 3, 32'h0F,
                        3'b001, 3'b010, 32'hF0F, 3'b000, 32'h0, 3'b000));
        vt.push_back(PRIV_EN ?
            mk(CSR_FUNCT3_RW, 12'h300, 32'h5, 5'd1, 5'd1, PRIV_U, 0, 32'h9,
               3'b000, 3'b000, 32'h0, 3'b000, 32'h0, 3'b001) :
            mk(CSR_FUNCT3_RW, 12'h300, 32'h5, 5'd1, 5'd1, PRIV_U, 0, 32'h9,
               3'b001, 3'b010, 32'h5, 3'b100, 32'h9, 3'b000));
        vt.push_back(PRIV_EN ?
            mk(CSR_FUNCT3_RW, 12'hF14, 32'h7, 5'd1, 5'd1, PRIV_M, 0, 32'h0,
               3'b000, 3'b000, 32'h0, 3'b000, 32'h0, 3'b001) :
            mk(CSR_FUNCT3_RW, 12'hF14, 32'h7, 5'd1, 5'd1, PRIV_M, 0, 32'h0,
               3'b001, 3'b010, 32'h7, 3'b100, 32'h0, 3'b000));
        vt.push_back(mk(CSR_FUNCT3_RS,  12'hF14, 32'h0, 5'd0, 5'd5, PRIV_M, 0, 32'hABC,
                        3'b001, 3'b000, 32'h0, 3'b100, 32'hABC, 3'b000));
        vt.push_back(mk(CSR_FUNCT3_RW,  12'h140, 32'h22, 5'd1, 5'd1, PRIV_S, 0, 32'h3,
                        3'b001, 3'b010, 32'h22, 3'b100, 32'h3, 3'b000));
        vt.push_back(PRIV_EN ?
            mk(CSR_FUNCT3_RS, 12'h300, 32'h0, 5'd0, 5'd1, PRIV_S, 0, 32'h44,
               3'b000, 3'b000, 32'h0, 3'b000, 32'h0, 3'b001) :
            mk(CSR_FUNCT3_RS, 12'h300, 32'h0, 5'd0, 5'd1, PRIV_S, 0, 32'h44,
               3'b001, 3'b000, 32'h0, 3'b100, 32'h44, 3'b000));
        vt.push_back(PRIV_EN ?
            mk(CSR_FUNCT3_RW, 12'h300, 32'h6, 5'd1, 5'd1, PRIV_U, 1, 32'h8,
               3'b000, 3'b000, 32'h0, 3'b000, 32'h0, 3'b000) :
            mk(CSR_FUNCT3_RW, 12'h300, 32'h6, 5'd1, 5'd1, PRIV_U, 1, 32'h8,
               3'b001, 3'b000, 32'h0, 3'b000, 32'h0, 3'b000));
        vt.push_back(mk(CSR_FUNCT3_RCI, 12'h7C0, 32'h0, 5'd0, 5'd2, PRIV_M, 0, 32'h5,
                        3'b001, 3'b000, 32'h0, 3'b100, 32'h5, 3'b000));

        foreach (vt[i]) begin
            preload(vt[i].op.addr, vt[i].init);
            run_op(vt[i].op, ob);
            compare($sformatf("vec%0d", i), ob, vt[i].want);
        end

        // Back-to-back: second request presented in the cycle right after the response
        preload(12'h340, 32'h1);
        o = '{f3: CSR_FUNCT3_RS, addr: 12'h340, rs1: 32'h2, idx: 5'd1, rd: 5'd1, priv: PRIV_M, flush_cyc: 0};
        run_op(o, ob);
        compare("b2b_a", ob, mk(CSR_FUNCT3_RS, 12'h340, 32'h2, 5'd1, 5'd1, PRIV_M, 0, 32'h1,
                                3'b001, 3'b010, 32'h3, 3'b100, 32'h1, 3'b000).want);
        o = '{f3: CSR_FUNCT3_RSI, addr: 12'h340, rs1: 32'h0, idx: 5'h4, rd: 5'd1, priv: PRIV_M, flush_cyc: 0};
        run_op(o, ob);
        compare("b2b_b", ob, mk(CSR_FUNCT3_RSI, 12'h340, 32'h0, 5'h4, 5'd1, PRIV_M, 0, 32'h3,
                                3'b001, 3'b010, 32'h7, 3'b100, 32'h3, 3'b000).want);
        model_mem[12'h340] = 32'h7;

        // Flush in IDLE blocks acceptance
        @(negedge clk);
        req_valid = 1'b1; req_funct3 = CSR_FUNCT3_RW; req_addr = 12'h341; req_rs1_data = 32'h99;
        req_rs1_idx = 5'd1; req_zimm = 5'd1; req_rd_idx = 5'd1; priv = PRIV_M; flush = 1'b1;
        #1 chk("flush_idle_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b0;
        #1 chk("flush_idle_no_ren", 32'(bus.csr_ren), 32'd0);
        chk("flush_idle_ready_after", 32'(req_ready), 32'd1);
        @(negedge clk);
        #1 chk("flush_idle_no_wen", 32'(bus.csr_wen), 32'd0);

        // Reset pulsed while in READ: no partial write, outputs back to reset values
        preload(12'h342, 32'h11112222);
        @(negedge clk);
        req_valid = 1'b1; req_funct3 = CSR_FUNCT3_RW; req_addr = 12'h342; req_rs1_data = 32'h99;
        req_rs1_idx = 5'd1; req_zimm = 5'd1; req_rd_idx = 5'd1; priv = PRIV_M; flush = 1'b0;
        @(negedge clk);
        req_valid = 1'b0; rst = 1'b1;
        #1 chk("rst_mid_ren_before", 32'(bus.csr_ren), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1 check_idle_outputs("rst_mid");
        @(negedge clk);
        #1 chk("rst_mid_no_wen_later", 32'(bus.csr_wen), 32'd0);
        @(negedge clk);
        #1 chk("rst_mid_csr_unchanged", mem[12'h342], 32'h11112222);
        o = '{f3: CSR_FUNCT3_RC, addr: 12'h342, rs1: 32'h2, idx: 5'd4, rd: 5'd3, priv: PRIV_M, flush_cyc: 0};
        run_op(o, ob);
        compare("after_rst", ob, model(o, model_mem[12'h342]));
        model_mem[12'h342] = 32'h11112220;

        // Randomized operations against the reference model
        pool[0] = 12'h340; pool[1] = 12'h341; pool[2] = 12'h300; pool[3] = 12'h304;
        pool[4] = 12'h140; pool[5] = 12'h040; pool[6] = 12'hC00; pool[7] = 12'hF14;
        pool[8] = 12'h7C0; pool[9] = 12'h280;
        f3s[0] = CSR_FUNCT3_RW;  f3s[1] = CSR_FUNCT3_RS;  f3s[2] = CSR_FUNCT3_RC;
        f3s[3] = CSR_FUNCT3_RWI; f3s[4] = CSR_FUNCT3_RSI; f3s[5] = CSR_FUNCT3_RCI;
        privs[0] = PRIV_U; privs[1] = PRIV_S; privs[2] = PRIV_M;
        for (int i = 0; i < 10; i++) preload(pool[i], $urandom);

        for (int n = 0; n < 150; n++) begin
            o.f3        = f3s[$urandom_range(0, 5)];
            o.addr      = pool[$urandom_range(0, 9)];
            o.rs1       = $urandom;
            o.idx       = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            o.rd        = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            o.priv      = privs[$urandom_range(0, 2)];
            o.flush_cyc = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0;
            want = model(o, model_mem[o.addr]);
            run_op(o, ob);
            compare($sformatf("rnd%0d", n), ob, want);
            if (want.wen != 3'b000) model_mem[o.addr] = want.wdata;
        end

        @(negedge clk);
        flush = 1'b0;
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
